rx_link_ctrl: RTL

- Controller that sits between the uart receiver (rx) and the frame consumer.
- Sequences the receiver: holds it in reset while disabled and watches for link stalls. On a stall it pulses a resync reset.
- Buffers each 162-bit frame delivered on the receiver's ready pulse in a 2-entry FIFO.
- Presents frames to the consumer over a valid/accept handshake, with drop and resync statistics.

---
 rtl/rx_link_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rx_link_ctrl.sv
// Two-entry in-order frame buffer with a registered head slot.
// Latency: push into empty -> head_vld/head_dat one cycle later; head holds its value when drained.
// Backpressure: push_rdy low only when full with no pop this cycle; pushes while not ready are ignored.
module fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat
);

  logic [1:0]       cnt;
  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;
  logic             pop_go;
  logic             push_go;

  // A pop frees the slot in the same cycle, so a full buffer still takes a push alongside it.
  assign pop_go   = (cnt != 2'd0) && pop_rdy;
  assign push_rdy = (cnt != 2'd2) || pop_go;
  assign push_go  = push_vld && push_rdy;
  assign head_vld = (cnt != 2'd0);
  assign head_dat = mem0;

  // mem0 is always the head; on pop the tail shifts forward, otherwise mem0 keeps its last frame.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt  <= 2'd0;
      mem0 <= '0;
      mem1 <= '0;
    end else begin
      cnt <= cnt + {1'b0, push_go} - {1'b0, pop_go};
      if (pop_go) begin
        if (cnt == 2'd2) mem0 <= mem1;
        if (push_go) begin
          if (cnt == 2'd1) mem0 <= push_dat;
          else             mem1 <= push_dat;
        end
      end else if (push_go) begin
        if (cnt == 2'd0) mem0 <= push_dat;
        else             mem1 <= push_dat;
      end
    end
  end

endmodule

// Receiver link sequencer: holds rx in reset when disabled, resyncs on stall, buffers frames for the consumer.
// Latency: frame_ready -> data_valid one cycle; state/rx_rst_out change one cycle after their cause.
// Backpressure: 2-entry buffer; a frame arriving while full without a same-cycle accept is dropped and counted.
module rx_link_ctrl #(
  parameter int WIDTH          = 162,
  parameter int TIMEOUT_CYCLES = 65000000,
  parameter int RESYNC_CYCLES  = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable,
  input  logic [WIDTH-1:0] frame_in,
  input  logic             frame_ready,
  output logic             rx_rst_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_accept,
  output logic             link_up,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] resync_count,
  output logic [1:0]       state_out
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam int RS_W = $clog2(RESYNC_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LISTEN = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic [RS_W-1:0] rs_cnt;
  logic            frm_vld;
  logic            frm_rdy;
  logic            pop_vld;

  // Frames are only taken while listening; IDLE and RESYNC ignore the receiver strobe.
  assign frm_vld   = frame_ready && (state == ST_LISTEN);
  assign pop_vld   = data_valid && data_accept;
  assign state_out = state;

  fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .core_clk (clk_in),
    .arst_n   (rst_in),
    .push_vld (frm_vld),
    .push_dat (frame_in),
    .push_rdy (frm_rdy),
    .pop_rdy  (data_accept),
    .head_vld (data_valid),
    .head_dat (data_out)
  );

  // Link FSM with registered rx reset, link status, watchdog and resync statistics; disable wins over everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= ST_IDLE;
      rx_rst_out   <= 1'b1;
      link_up      <= 1'b0;
      wd_cnt       <= '0;
      rs_cnt       <= '0;
      resync_count <= '0;
    end else if (!enable) begin
      state      <= ST_IDLE;
      rx_rst_out <= 1'b1;
      link_up    <= 1'b0;
      wd_cnt     <= '0;
      rs_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_LISTEN;
          rx_rst_out <= 1'b0;
          link_up    <= 1'b0;
          wd_cnt     <= '0;
        end
        ST_LISTEN: begin
          if (frame_ready) begin
            // Any strobe, including one that ends up dropped, proves the link is alive.
            wd_cnt  <= '0;
            link_up <= 1'b1;
          end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state      <= ST_RESYNC;
            rx_rst_out <= 1'b1;
            link_up    <= 1'b0;
            rs_cnt     <= '0;
            if (resync_count != {CNT_W{1'b1}}) resync_count <= resync_count + 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_RESYNC: begin
          if (rs_cnt == RS_W'(RESYNC_CYCLES - 1)) begin
            state      <= ST_LISTEN;
            rx_rst_out <= 1'b0;
            wd_cnt     <= '0;
          end else begin
            rs_cnt <= rs_cnt + RS_W'(1);
          end
        end
        default: begin
          state      <= ST_IDLE;
          rx_rst_out <= 1'b1;
          link_up    <= 1'b0;
        end
      endcase
    end
  end

  // Count frames lost to a full buffer; saturate instead of wrapping.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      drop_count <= '0;
    end else if (frm_vld && !frm_rdy && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule
